// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-cycle data memory port: latch one request, drive memory for LAT cycles, pulse rvalid on loads.
// Optional ARB_FIXED_PRIO_EN: requester 0 always wins ties (default build is round-robin).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LAT    = 2,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              req0_ready,
  output logic [31:0]       req0_rdata,
  output logic              req0_rvalid,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              req1_ready,
  output logic [31:0]       req1_rdata,
  output logic              req1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data_in [0:3],
  input  logic [7:0]        mem_data_out [0:3],
  output logic              mem_write_en,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

  // Handshake: a request is taken in the IDLE cycle where valid and ready are both high.
  logic [1:0]        state;
  logic              gnt_idx;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              grant0;
  logic              grant1;
  logic [31:0]       rd_word;
  logic              in_access;

`ifndef ARB_FIXED_PRIO_EN
  logic              last_grant;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
`ifdef ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  assign rd_word = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      gnt_idx    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            gnt_idx   <= grant1;
            lat_we    <= grant1 ? req1_we    : req0_we;
            lat_addr  <= grant1 ? req1_addr  : req0_addr;
            lat_wdata <= grant1 ? req1_wdata : req0_wdata;
            cnt       <= LAT_M1;
            state     <= S_ACCESS;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= grant1;
`endif
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (lat_we) begin
              state <= S_IDLE;
            end else begin
              if (gnt_idx) req1_rdata <= rd_word;
              else         req0_rdata <= rd_word;
              state <= S_RESP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory-side outputs decode from state so that reset drops the write strobe asynchronously.
  assign in_access    = (state == S_ACCESS);
  assign mem_addr     = in_access ? lat_addr : '0;
  assign mem_write_en = in_access && lat_we;
  assign busy         = (state != S_IDLE);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_data_in[i] = in_access ? lat_wdata[31-8*i -: 8] : 8'h00;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign req0_rvalid = (state == S_RESP) && !gnt_idx;
  assign req1_rvalid = (state == S_RESP) && gnt_idx;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random traffic from both requesters checked against a
// transaction-level model (word memory, arbitration rule, cycle schedule).
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LAT    = 2;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk;
  logic              rst_b;
  logic              req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [ADDR_W-1:0] req0_addr;
  logic [31:0]       req0_wdata, req0_rdata;
  logic              req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [ADDR_W-1:0] req1_addr;
  logic [31:0]       req1_wdata, req1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data_in [0:3];
  logic [7:0]        mem_data_out [0:3];
  logic              mem_write_en;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .busy(busy)
  );

  // ---------------- clock / reset / memory instance ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] tb_mem [0:15];
  always_comb begin
    for (int i = 0; i < 4; i++) mem_data_out[i] = tb_mem[mem_addr[5:2]][31-8*i -: 8];
  end
  always @(posedge clk) begin
    if (mem_write_en)
      tb_mem[mem_addr[5:2]] <= {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [32:0] exp_q [$];   // {requester id, load data}
  int          due_q [$];   // cycle the rvalid pulse is expected in
  logic [31:0] ref_mem [0:15];
  logic        mon_en = 1'b0;
  int          m_last = 1;
  int          m_free = 0;
  int          m_gcyc = 0;
  logic        m_act = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = 1;
    m_free = 0;
    m_act  = 1'b0;
    exp_q.delete();
    due_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    logic        exp_any, in_acc, in_resp;
    int          g;
    logic [32:0] e;
    int          d;
    if (mon_en) begin
      exp_any = (req0_valid || req1_valid) && (cyc >= m_free);
      check("ready_any", 64'(req0_ready | req1_ready), 64'(exp_any));
      check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
      if (exp_any) begin
        if (req0_valid && req1_valid) g = FIXED ? 0 : (m_last == 1 ? 0 : 1);
        else g = req1_valid ? 1 : 0;
        check("grant_idx", 64'(req1_ready), 64'(g));
        m_last  = g;
        m_act   = 1'b1;
        m_gcyc  = cyc;
        m_we    = (g == 1) ? req1_we    : req0_we;
        m_addr  = (g == 1) ? req1_addr  : req0_addr;
        m_wdata = (g == 1) ? req1_wdata : req0_wdata;
        m_free  = cyc + LAT + (m_we ? 1 : 2);
        if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
        else begin
          exp_q.push_back({g[0], ref_mem[m_addr[5:2]]});
          due_q.push_back(cyc + LAT + 1);
        end
      end
      in_acc  = m_act && (cyc > m_gcyc) && (cyc <= m_gcyc + LAT);
      in_resp = m_act && !m_we && (cyc == m_gcyc + LAT + 1);
      check("write_en", 64'(mem_write_en), 64'(in_acc && m_we));
      if (!in_resp) check("busy", 64'(busy), 64'(in_acc));
      if (in_acc) begin
        check("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (m_we) begin
          for (int i = 0; i < 4; i++)
            check($sformatf("lane%0d", i), 64'(mem_data_in[i]), 64'((m_wdata >> (8 * (3 - i))) & 32'hff));
        end
      end
      check("rvalid_onehot", 64'(req0_rvalid & req1_rvalid), 64'd0);
      if (req0_rvalid || req1_rvalid) begin
        if (exp_q.size() == 0) begin
          check("rvalid_spurious", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          check("rsp_id", 64'(req1_rvalid), 64'(e[32]));
          check("rsp_data", 64'(req1_rvalid ? req1_rdata : req0_rdata), 64'(e[31:0]));
          check("rsp_cycle", 64'(cyc), 64'(d));
        end
      end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
        check("rvalid_missing", 64'(0), 64'(1));
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int n, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gap, output int waited);
    logic got;
    repeat (gap) begin @(posedge clk); #1; end
    if (n == 0) begin req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata; end
    else        begin req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata; end
    waited = 0;
    got = 1'b0;
    while (!got && waited <= 200) begin
      @(negedge clk);
      got = (n == 0) ? req0_ready : req1_ready;
      if (!got) waited++;
    end
    if (!got) check($sformatf("ready%0d_timeout", n), 64'(0), 64'(1));
    @(posedge clk); #1;
    // Fields are scrambled after acceptance; the latched transaction must be unaffected.
    if (n == 0) begin req0_valid = 1'b0; req0_we = 1'($urandom); req0_addr = $urandom; req0_wdata = 32'h0; end
    else        begin req1_valid = 1'b0; req1_we = 1'($urandom); req1_addr = $urandom; req1_wdata = $urandom; end
  endtask

  task automatic run_random(input int n, input int count);
    int w;
    for (int i = 0; i < count; i++)
      issue(n, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
            $urandom_range(0, 6), w);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || cyc < m_free) && k < 100) begin @(posedge clk); k++; end
    if (k >= 100) check("drain_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int w;
    for (int i = 0; i < 16; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end
    rst_b = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_ready1", 64'(req1_ready), 64'd0);
    check("rst_rvalid0", 64'(req0_rvalid), 64'd0);
    check("rst_rvalid1", 64'(req1_rvalid), 64'd0);
    check("rst_rdata0", 64'(req0_rdata), 64'd0);
    check("rst_rdata1", 64'(req1_rdata), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data_in", 64'({mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]}), 64'd0);
    check("rst_write_en", 64'(mem_write_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_b  = 1'b1;
    mon_en = 1'b1;

    // Store then load of the same word.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, w);
    check("store_ready_cycle0", 64'(w), 64'd0);
    issue(1, 1'b0, 32'h10, 32'h0, 0, w);
    wait_drain();

    // Both requesters held valid with loads.
    fork
      begin for (int i = 0; i < 2; i++) issue(0, 1'b0, 32'(i * 4), 32'h0, 0, w); end
      begin int w1; for (int i = 0; i < 2; i++) issue(1, 1'b0, 32'h10, 32'h0, 0, w1); end
    join
    wait_drain();

    // Reset during the last ACCESS cycle of a store.
    mon_en = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h20; req0_wdata = 32'h12345678;
    @(negedge clk);
    check("abort_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_we_before", 64'(mem_write_en), 64'd1);
    rst_b = 1'b0;
    #1;
    check("abort_we_async", 64'(mem_write_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    ref_mem[8] = 32'h12345678;   // the first ACCESS edge already wrote the word
    repeat (2) begin
      @(negedge clk);
      check("abort_no_rvalid", 64'(req0_rvalid | req1_rvalid), 64'd0);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    model_reset();
    mon_en = 1'b1;
    issue(1, 1'b0, 32'h20, 32'h0, 0, w);
    check("post_reset_grant_wait", 64'(w), 64'd0);
    wait_drain();

    // Randomized traffic from both requesters.
    fork
      run_random(0, 40);
      run_random(1, 40);
    join
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
